gpr_operand_fetch: RTL

- Read-side front end for the single-port general-purpose register file (one shared address for read and write, combinational read data).
- Accepts a decode-stage request naming two source registers (rs, rt) and reads both through the one port, serially.
- Returns the operand pair to the execute stage over a valid/ready handshake.
- Also owns the port's write side: writeback writes always win the port, fetch stalls around them, and captured operands are bypass-updated by later writes. MIPS $0 reads as zero and is never written.

---
 rtl/gpr_operand_fetch_if.sv | 36 +++
 rtl/gpr_operand_fetch.sv | 94 +++++++++
 2 files changed

// File: rtl/gpr_operand_fetch_if.sv
// Bundle of the decode request, writeback, execute-side and register-file port
// signals for gpr_operand_fetch.
interface gpr_operand_fetch_if #(
  parameter int N = 32,
  parameter int K = 5
);
  // req and out are valid/ready channels: a transfer happens on a rising edge
  // where valid and ready are both 1; the sender holds its payload stable while
  // valid is 1 and ready is 0. wb has no ready and is taken in any cycle it is valid.
  logic         req_valid;
  logic         req_ready;
  logic [K-1:0] req_rs;
  logic [K-1:0] req_rt;
  logic         wb_valid;
  logic [K-1:0] wb_addr;
  logic [N-1:0] wb_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_a;
  logic [N-1:0] out_b;
  logic [K-1:0] gpr_address;
  logic [N-1:0] gpr_d;
  logic         gpr_wren;
  logic [N-1:0] gpr_q;
  logic [1:0]   state;

  modport master (
    output req_valid, req_rs, req_rt, wb_valid, wb_addr, wb_data, out_ready, gpr_q,
    input  req_ready, out_valid, out_a, out_b, gpr_address, gpr_d, gpr_wren, state
  );

  modport slave (
    input  req_valid, req_rs, req_rt, wb_valid, wb_addr, wb_data, out_ready, gpr_q,
    output req_ready, out_valid, out_a, out_b, gpr_address, gpr_d, gpr_wren, state
  );
endinterface

// File: rtl/gpr_operand_fetch.sv
// Serial two-operand fetch through a single-port register file; writeback owns
// the port whenever it is valid, and captured operands follow later writes.
module gpr_operand_fetch #(
  parameter int N    = 32,
  parameter int Nreg = 32,
  parameter int K    = $clog2(Nreg)
) (
  input logic clk,
  input logic rst,
  gpr_operand_fetch_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_RS = 2'd1,
    RD_RT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state;
  logic [K-1:0] rs;
  logic [K-1:0] rt;
  logic         wb_live;
  logic         hit_a;
  logic         hit_b;

  // A write to $0 never reaches the file and never bypasses.
  assign wb_live = bus.wb_valid && (bus.wb_addr != '0);
  assign hit_a   = wb_live && (bus.wb_addr == rs);
  assign hit_b   = wb_live && (bus.wb_addr == rt);
  assign bus.state = state;

  always_comb begin
    bus.gpr_address = '0;
    bus.gpr_d       = bus.wb_data;
    bus.gpr_wren    = 1'b0;
    if (bus.wb_valid) begin
      bus.gpr_address = bus.wb_addr;
      bus.gpr_wren    = wb_live;
    end else if (state == RD_RS) begin
      bus.gpr_address = rs;
    end else if (state == RD_RT) begin
      bus.gpr_address = rt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.req_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_a     <= '0;
      bus.out_b     <= '0;
      rs            <= '0;
      rt            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            rs            <= bus.req_rs;
            rt            <= bus.req_rt;
            bus.req_ready <= 1'b0;
            state         <= RD_RS;
          end
        end
        RD_RS: begin
          if (!bus.wb_valid) begin
            bus.out_a <= (rs == '0) ? '0 : bus.gpr_q;
            state     <= RD_RT;
          end
        end
        RD_RT: begin
          if (bus.wb_valid) begin
            if (hit_a) bus.out_a <= bus.wb_data;
          end else begin
            bus.out_b     <= (rt == '0) ? '0 : bus.gpr_q;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          // Bypass still lands on the handshake edge; the consumer saw the old value.
          if (hit_a) bus.out_a <= bus.wb_data;
          if (hit_b) bus.out_b <= bus.wb_data;
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
